// File: rtl/register_file.sv
// register_file: 2^ADDR_WIDTH x DATA_WIDTH general-purpose register file.
// One synchronous write port and two registered read ports (A, B), each with
// its own read enable. A same-edge read of the address being written returns
// the new write data (write-first).
// Optional macro REGFILE_ZERO_REG_EN: register 0 is hardwired to zero, writes
// to it are dropped and reads of it always return 0.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic                  WriteEn,
  input  logic [ADDR_WIDTH-1:0] ReadA,
  input  logic                  ReadAEn,
  output logic [DATA_WIDTH-1:0] data_oA,
  input  logic [ADDR_WIDTH-1:0] ReadB,
  input  logic                  ReadBEn,
  output logic [DATA_WIDTH-1:0] data_oB
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_a_d;
  logic [DATA_WIDTH-1:0] rd_b_d;
  logic                  wr_ok;

  // Qualify the write: with the zero register enabled, address 0 is never stored.
  always_comb begin
`ifdef REGFILE_ZERO_REG_EN
    wr_ok = WriteEn && (WriteAddr != '0);
`else
    wr_ok = WriteEn;
`endif
  end

  // Next read data per port: write-first bypass, then storage; address 0 forced
  // to zero when the zero register is enabled.
  always_comb begin
    rd_a_d = mem_q[ReadA];
    rd_b_d = mem_q[ReadB];
    if (wr_ok && (WriteAddr == ReadA)) rd_a_d = data_i;
    if (wr_ok && (WriteAddr == ReadB)) rd_b_d = data_i;
`ifdef REGFILE_ZERO_REG_EN
    if (ReadA == '0) rd_a_d = '0;
    if (ReadB == '0) rd_b_d = '0;
`endif
  end

  // Register storage: asynchronous clear of every entry, synchronous write.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_WIDTH'(i)] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[WriteAddr] <= data_i;
    end
  end

  // Registered read outputs; each holds its value while its enable is low.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_oA <= '0;
      data_oB <= '0;
    end else begin
      if (ReadAEn) data_oA <= rd_a_d;
      if (ReadBEn) data_oB <= rd_b_d;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against a
// behavioural array model. Honours REGFILE_ZERO_REG_EN when defined.
module tb_register_file;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          Clk;
  logic          Rst_n;
  logic [DW-1:0] data_i;
  logic [AW-1:0] WriteAddr;
  logic          WriteEn;
  logic [AW-1:0] ReadA;
  logic          ReadAEn;
  logic [DW-1:0] data_oA;
  logic [AW-1:0] ReadB;
  logic          ReadBEn;
  logic [DW-1:0] data_oB;

  int errors = 0;
  int checks = 0;

  // Behavioural model: plain array plus the two last-read values.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_a;
  logic [DW-1:0] ref_b;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .data_i(data_i), .WriteAddr(WriteAddr),
    .WriteEn(WriteEn), .ReadA(ReadA), .ReadAEn(ReadAEn), .data_oA(data_oA),
    .ReadB(ReadB), .ReadBEn(ReadBEn), .data_oB(data_oB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic zero_reg();
`ifdef REGFILE_ZERO_REG_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (zero_reg() && a == '0) return '0;
    return ref_mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_a = '0;
    ref_b = '0;
  endtask

  // One clock: the write lands first, so same-edge reads see the new data.
  task automatic step();
    @(posedge Clk);
    if (Rst_n) begin
      if (WriteEn && !(zero_reg() && WriteAddr == '0)) ref_mem[WriteAddr] = data_i;
      if (ReadAEn) ref_a = model_read(ReadA);
      if (ReadBEn) ref_b = model_read(ReadB);
    end
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    WriteEn = 1'b0; ReadAEn = 1'b0; ReadBEn = 1'b0;
    WriteAddr = '0; ReadA = '0; ReadB = '0; data_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (data_oA !== '0 || data_oB !== '0) begin
      errors++;
      $display("FAIL reset_initial got A=%h B=%h exp 0", data_oA, data_oB);
    end
    @(negedge Clk) Rst_n = 1'b1;
    // Put nonzero data in the outputs, then reset mid-cycle.
    WriteEn = 1'b1; WriteAddr = AW'(1); data_i = 32'hA5A5_0001;
    step();
    WriteAddr = AW'(2); data_i = 32'h5A5A_0002;
    ReadAEn = 1'b1; ReadA = AW'(1); ReadBEn = 1'b1; ReadB = AW'(2);
    step();
    checks++;
    if (data_oA !== 32'hA5A5_0001 || data_oB !== 32'h5A5A_0002) begin
      errors++;
      $display("FAIL reset_prefill got A=%h B=%h exp A=a5a50001 B=5a5a0002", data_oA, data_oB);
    end
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (data_oA !== '0 || data_oB !== '0) begin
      errors++;
      $display("FAIL reset_async got A=%h B=%h exp 0", data_oA, data_oB);
    end
    // Activity during reset is ignored.
    WriteEn = 1'b1; WriteAddr = AW'(3); data_i = 32'hFFFF_FFFF;
    ReadA = AW'(3); ReadB = AW'(3);
    step();
    checks++;
    if (data_oA !== '0 || data_oB !== '0) begin
      errors++;
      $display("FAIL reset_hold got A=%h B=%h exp 0", data_oA, data_oB);
    end
    idle_inputs();
    Rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ReadAEn = 1'b1; ReadA = AW'(i);
      ReadBEn = 1'b1; ReadB = AW'(DEPTH - 1 - i);
      step();
      checks++;
      if (data_oA !== '0 || data_oB !== '0) begin
        errors++;
        $display("FAIL reset_clear i=%0d got A=%h B=%h exp 0", i, data_oA, data_oB);
      end
    end
    idle_inputs();
  endtask

  task automatic test_sweep();
    logic [DW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      WriteEn = 1'b1; WriteAddr = AW'(i); data_i = DW'(i);
      step();
    end
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      exp = (zero_reg() && i == 0) ? '0 : DW'(i);
      ReadAEn = 1'b1; ReadA = AW'(i);
      step();
      ReadAEn = 1'b0;
      checks++;
      if (data_oA !== exp) begin
        errors++;
        $display("FAIL sweep_a addr=%0d got=%h exp=%h", i, data_oA, exp);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = (zero_reg() && i == 0) ? '0 : DW'(i);
      ReadBEn = 1'b1; ReadB = AW'(i);
      step();
      ReadBEn = 1'b0;
      checks++;
      if (data_oB !== exp) begin
        errors++;
        $display("FAIL sweep_b addr=%0d got=%h exp=%h", i, data_oB, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_enable_hold();
    ReadAEn = 1'b1; ReadA = AW'(5);
    step();
    checks++;
    if (data_oA !== DW'(5)) begin
      errors++;
      $display("FAIL hold_read got=%h exp=%h", data_oA, DW'(5));
    end
    ReadAEn = 1'b0; ReadA = AW'(9);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (data_oA !== DW'(5)) begin
        errors++;
        $display("FAIL hold_cycle%0d got=%h exp=%h", c, data_oA, DW'(5));
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_disabled();
    WriteEn = 1'b0; WriteAddr = AW'(4); data_i = 32'h1234_5678;
    step();
    idle_inputs();
    ReadAEn = 1'b1; ReadA = AW'(4);
    step();
    checks++;
    if (data_oA !== DW'(4)) begin
      errors++;
      $display("FAIL write_disabled got=%h exp=%h", data_oA, DW'(4));
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp0;
    WriteEn = 1'b1; WriteAddr = AW'(7); data_i = 32'hDEAD_BEEF;
    ReadAEn = 1'b1; ReadA = AW'(7); ReadBEn = 1'b1; ReadB = AW'(7);
    step();
    checks++;
    if (data_oA !== 32'hDEAD_BEEF || data_oB !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_7 got A=%h B=%h exp deadbeef", data_oA, data_oB);
    end
    exp0 = zero_reg() ? '0 : 32'hFFFF_FFFF;
    WriteAddr = '0; data_i = 32'hFFFF_FFFF; ReadA = '0; ReadB = '0;
    step();
    checks++;
    if (data_oA !== exp0 || data_oB !== exp0) begin
      errors++;
      $display("FAIL bypass_0 got A=%h B=%h exp=%h", data_oA, data_oB, exp0);
    end
    idle_inputs();
    ReadAEn = 1'b1; ReadA = '0;
    step();
    checks++;
    if (data_oA !== exp0) begin
      errors++;
      $display("FAIL reg0_after got=%h exp=%h", data_oA, exp0);
    end
    idle_inputs();
  endtask

  task automatic test_dual_port();
    ReadAEn = 1'b1; ReadA = AW'(3); ReadBEn = 1'b1; ReadB = AW'(30);
    step();
    checks++;
    if (data_oA !== DW'(3) || data_oB !== DW'(30)) begin
      errors++;
      $display("FAIL dual_both got A=%h B=%h exp A=3 B=1e", data_oA, data_oB);
    end
    ReadAEn = 1'b0; ReadA = AW'(20); ReadB = AW'(12);
    step();
    checks++;
    if (data_oA !== DW'(3) || data_oB !== DW'(12)) begin
      errors++;
      $display("FAIL dual_b_only got A=%h B=%h exp A=3 B=c", data_oA, data_oB);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      WriteEn   = 1'($urandom);
      data_i    = DW'($urandom);
      ReadAEn   = 1'($urandom);
      ReadBEn   = 1'($urandom);
      // Narrow address range half the time to force collisions and bypasses.
      if ($urandom_range(0, 1) == 0) begin
        WriteAddr = AW'($urandom_range(0, 3));
        ReadA     = AW'($urandom_range(0, 3));
        ReadB     = AW'($urandom_range(0, 3));
      end else begin
        WriteAddr = AW'($urandom);
        ReadA     = AW'($urandom);
        ReadB     = AW'($urandom);
      end
      step();
      checks++;
      if (data_oA !== ref_a || data_oB !== ref_b) begin
        errors++;
        $display("FAIL random c=%0d got A=%h B=%h exp A=%h B=%h", c, data_oA, data_oB, ref_a, ref_b);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_enable_hold();
    test_write_disabled();
    test_bypass();
    test_dual_port();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 2^ADDR_WIDTH x DATA_WIDTH general-purpose register file (default 32 x 32).
- One synchronous write port and two independent read ports (A, B).
- Each read port has a registered output with a per-port read enable.
- Serves as the operand store for the datapath: ports A and B feed the two ALU operands, and the write port takes the writeback.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, address width; depth = 2^ADDR_WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- data_i  input  DATA_WIDTH  write data.
- WriteAddr  input  ADDR_WIDTH  write address.
- WriteEn  input  1  write enable, active high.
- ReadA  input  ADDR_WIDTH  port A read address.
- ReadAEn  input  1  port A read enable, active high.
- data_oA  output  DATA_WIDTH  port A registered read data.
- ReadB  input  ADDR_WIDTH  port B read address.
- ReadBEn  input  1  port B read enable, active high.
- data_oB  output  DATA_WIDTH  port B registered read data.

Behaviour:
- Reset:
  - Rst_n low clears every register, data_oA and data_oB to 0 immediately, with no clock needed.
  - Writes and reads are ignored while Rst_n is low.
  - Deassertion is synchronised externally by the integrator.
- Write: on a rising Clk with WriteEn=1, mem[WriteAddr] <= data_i. With WriteEn=0, memory is unchanged.
- Read A: on a rising Clk with ReadAEn=1, data_oA <= mem[ReadA]. With ReadAEn=0, data_oA holds its previous value.
- Read B: identical to read A, using ReadB, ReadBEn and data_oB.
- Read latency: one clock. Data is valid after the edge that samples the enable, and stays valid until the next enabled read or reset.
- Read-during-write, same edge, same address: the read port returns the new data_i (write-first bypass). This applies to each port independently.
- Both read ports may read the same address on the same edge; both return identical data.
- Every address 0..2^ADDR_WIDTH-1 is valid. There is no out-of-range case and no wrap logic.
- No X propagation:
  - Reading a never-written register after reset returns 0.
  - Address inputs are don't-care when their enable is low.
- No handshake and no back-pressure; one write and two reads can complete every cycle.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- When defined:
  - Register 0 is hardwired to zero; writes to address 0 are discarded.
  - Reads of address 0 always return 0, including the same-edge bypass case (a write of 0xFFFFFFFF to address 0 while reading address 0 returns 0).
- When undefined: register 0 is an ordinary read/write register like all others.

Test Plan:
- Reset: assert Rst_n=0 mid-cycle after writes -> data_oA=data_oB=0 immediately. Then, after release, reads of every address return 0.
- Write/read sweep: for i=0..31, write data_i=i at WriteAddr=i. Then read ReadA=i with ReadAEn pulsed for one clock -> data_oA=i one clock later. Repeat on port B -> data_oB=i. Under REGFILE_ZERO_REG_EN, address 0 returns 0.
- Enable hold: read ReadA=5 -> data_oA=5. Then set ReadAEn=0 and ReadA=9 -> data_oA stays 5 for 3 clocks.
- Bypass: with mem[7]=7, on the same edge set WriteEn=1, WriteAddr=7, data_i=32'hDEADBEEF, and ReadA=ReadB=7 with both enables high -> data_oA=data_oB=32'hDEADBEEF.
- Dual port independence: ReadA=3 and ReadB=30 on the same edge -> data_oA=3, data_oB=30. Then only ReadBEn=1 with ReadB=12 -> data_oB=12 while data_oA stays 3.
- Write disabled: WriteEn=0, WriteAddr=4, data_i=32'h12345678 -> a later read of 4 still returns 4.
